// File: rtl/uart_cmd_frame_tx.sv
// uart_cmd_frame_tx: turns one host command into protocol bytes and sends each as a UART frame (CLK/Reset, Cmd_* in, Tx_serial/Busy/Frame_done out)
module uart_cmd_frame_tx #(
  parameter int width = 8,
  parameter int addr_width = 4,
  parameter int Gap_bits = 1
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Cmd_valid,
  input  logic [1:0]            Cmd_type,
  input  logic [addr_width-1:0] Addr,
  input  logic [width-1:0]      Data_A,
  input  logic [width-1:0]      Data_B,
  input  logic [3:0]            Fun,
  input  logic                  Parity_EN,
  input  logic                  Parity_type,
  input  logic [4:0]            Prescale,
  output logic                  Tx_serial,
  output logic                  Busy,
  output logic                  Frame_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP, DONE} state_t;
  localparam logic [7:0] DATA_LAST = 8'(width - 1);
  localparam logic [7:0] GAP_LAST = 8'(Gap_bits - 1);
  state_t state;
  logic [4:0] cyc, p_last, p_clamp;
  logic [7:0] bcnt;
  logic [2:0] nleft, cmd_len;
  logic [4*width-1:0] frm, cmd_frm;
  logic [width-1:0] shf, cur;
  logic pe_q, pt_q, bit_end, adv;
  always_comb begin
    cmd_frm = Cmd_type == 2'd0 ? {{width{1'b0}}, Data_A, width'(Addr), width'(8'hAA)} :
              Cmd_type == 2'd1 ? {{(2*width){1'b0}}, width'(Addr), width'(8'hBB)} :
              Cmd_type == 2'd2 ? {width'(Fun), Data_B, Data_A, width'(8'hCC)} :
                                 {{(2*width){1'b0}}, width'(Fun), width'(8'hDD)};
    cmd_len = Cmd_type == 2'd0 ? 3'd3 : Cmd_type == 2'd2 ? 3'd4 : 3'd2;
    p_clamp = Prescale < 5'd4 ? 5'd3 : Prescale - 5'd1;
    cur = frm[width-1:0];
    bit_end = cyc == p_last;
    adv = bit_end && ((state == STOP && Gap_bits == 0) || (state == GAP && bcnt == GAP_LAST));
  end
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      Tx_serial <= 1'b1;
      Busy <= 1'b0;
      Frame_done <= 1'b0;
      cyc <= '0;
      p_last <= '0;
      bcnt <= '0;
      nleft <= '0;
      frm <= '0;
      shf <= '0;
      pe_q <= 1'b0;
      pt_q <= 1'b0;
    end else begin
      Frame_done <= 1'b0;
      cyc <= (state == IDLE || state == DONE || bit_end) ? '0 : cyc + 5'd1;
      case (state)
        IDLE, DONE: begin
          if (Cmd_valid) begin
            frm <= cmd_frm;
            nleft <= cmd_len;
            p_last <= p_clamp;
            pe_q <= Parity_EN;
            pt_q <= Parity_type;
            state <= START;
            Tx_serial <= 1'b0;
            Busy <= 1'b1;
          end else state <= IDLE;
        end
        START: if (bit_end) begin
          state <= DATA;
          Tx_serial <= cur[0];
          shf <= cur >> 1;
          bcnt <= '0;
        end
        DATA: if (bit_end) begin
          if (bcnt == DATA_LAST) begin
            state <= pe_q ? PARITY : STOP;
            Tx_serial <= pe_q ? (^cur ^ pt_q) : 1'b1;
          end else begin
            bcnt <= bcnt + 8'd1;
            Tx_serial <= shf[0];
            shf <= shf >> 1;
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          Tx_serial <= 1'b1;
        end
        STOP: if (bit_end) begin
          state <= GAP;
          bcnt <= '0;
        end
        GAP: if (bit_end) bcnt <= bcnt + 8'd1;
        default: state <= IDLE;
      endcase
      if (adv) begin
        if (nleft == 3'd1) begin
          state <= DONE;
          Busy <= 1'b0;
          Frame_done <= 1'b1;
        end else begin
          state <= START;
          Tx_serial <= 1'b0;
          nleft <= nleft - 3'd1;
          frm <= frm >> width;
        end
      end
    end
endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// tb_uart_cmd_frame_tx: table-driven commands with a serial-line scoreboard for uart_cmd_frame_tx
module tb_uart_cmd_frame_tx;
  logic CLK = 1'b0, Reset = 1'b1, Cmd_valid = 1'b0, Parity_EN = 1'b0, Parity_type = 1'b0;
  logic [1:0] Cmd_type = '0;
  logic [3:0] Addr = '0, Fun = '0;
  logic [7:0] Data_A = '0, Data_B = '0;
  logic [4:0] Prescale = '0;
  logic Tx_serial, Busy, Frame_done;
  typedef struct {
    logic [1:0] typ;
    logic [3:0] addr;
    logic [7:0] a, b;
    logic [3:0] fun;
    logic pe, pt;
    logic [4:0] pre;
    int nb;
    logic [31:0] bytes;
    int low;
    int cyc;
  } vec_t;
  vec_t tbl[7];
  logic [8:0] sb[$];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, mpm = 4;
  logic mpe = 1'b0, rst_seen = 1'b0;
  uart_cmd_frame_tx dut (
    .CLK(CLK), .Reset(Reset), .Cmd_valid(Cmd_valid), .Cmd_type(Cmd_type), .Addr(Addr),
    .Data_A(Data_A), .Data_B(Data_B), .Fun(Fun), .Parity_EN(Parity_EN), .Parity_type(Parity_type),
    .Prescale(Prescale), .Tx_serial(Tx_serial), .Busy(Busy), .Frame_done(Frame_done)
  );
  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  initial forever begin
    @(negedge Reset);
    rst_seen = 1'b1;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  initial begin
    logic [7:0] b;
    logic pb, st, s0, epe;
    logic [8:0] e;
    int p;
    forever begin
      @(negedge CLK);
      if (Reset && Tx_serial === 1'b0) begin
        rst_seen = 1'b0;
        p = mpm;
        epe = mpe;
        repeat (p / 2) @(negedge CLK);
        s0 = Tx_serial;
        for (int i = 0; i < 8; i++) begin
          repeat (p) @(negedge CLK);
          b[i] = Tx_serial;
        end
        pb = 1'b0;
        if (epe) begin
          repeat (p) @(negedge CLK);
          pb = Tx_serial;
        end
        repeat (p) @(negedge CLK);
        st = Tx_serial;
        if (!rst_seen) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h expected=none", b);
          end else begin
            e = sb.pop_front();
            chk("start_bit", s0, 0);
            chk("data_byte", b, e[7:0]);
            if (epe) chk("parity_bit", pb, e[8]);
            chk("stop_bit", st, 1);
          end
        end
      end
    end
  end
  task automatic issue(input vec_t v);
    logic [7:0] x;
    mpm = v.pre < 5'd4 ? 4 : int'(v.pre);
    mpe = v.pe;
    for (int i = 0; i < v.nb; i++) begin
      x = v.bytes[i*8 +: 8];
      sb.push_back({^x ^ v.pt, x});
    end
    Cmd_type = v.typ;
    Addr = v.addr;
    Data_A = v.a;
    Data_B = v.b;
    Fun = v.fun;
    Parity_EN = v.pe;
    Parity_type = v.pt;
    Prescale = v.pre;
    Cmd_valid = 1'b1;
    @(posedge CLK);
    #1;
    Cmd_valid = 1'b0;
    acc_cyc = cyc;
    chk("accept_busy", Busy, 1);
    chk("accept_start_low", Tx_serial, 0);
  endtask
  task automatic wait_done(input int exp, input string nm);
    logic drop;
    drop = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge CLK);
      #1;
      if (Frame_done) break;
      if (!Busy) drop = 1'b1;
    end
    if (!Frame_done) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout actual=none expected=%0d", nm, exp);
    end else begin
      chk({nm, "_cycles"}, cyc - acc_cyc, exp);
      chk({nm, "_busy_low"}, Busy, 0);
      chk({nm, "_busy_held"}, drop, 0);
    end
  endtask
  initial begin
    int n;
    tbl[0] = '{2'd0, 4'h3, 8'h5A, 8'h00, 4'h0, 1'b0, 1'b0, 5'd8,  3, 32'h005A03AA, 16, 264};
    tbl[1] = '{2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 5'd16, 2, 32'h000002BB, 16, 384};
    tbl[2] = '{2'd2, 4'h0, 8'h07, 8'h03, 4'h1, 1'b1, 1'b1, 5'd8,  4, 32'h010307CC, 24, 384};
    tbl[3] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'hF, 1'b0, 1'b0, 5'd2,  2, 32'h00000FDD, 4,  88};
    tbl[4] = '{2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 5'd31, 2, 32'h00000FBB, 31, 682};
    tbl[5] = '{2'd0, 4'h0, 8'h81, 8'h00, 4'h0, 1'b1, 1'b1, 5'd4,  3, 32'h008100AA, 8,  144};
    tbl[6] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'h2, 1'b0, 1'b0, 5'd8,  2, 32'h000002DD, 8,  176};
    #3 Reset = 1'b0;
    #1;
    chk("reset_tx", Tx_serial, 1);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Frame_done, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i]);
      n = 0;
      while (Tx_serial === 1'b0 && n < 2000) begin
        n++;
        @(posedge CLK);
        #1;
      end
      chk($sformatf("vec%0d_first_low_len", i), n, tbl[i].low);
      wait_done(tbl[i].cyc, $sformatf("vec%0d", i));
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), Frame_done, 0);
    end
    issue(tbl[0]);
    repeat (100) @(posedge CLK);
    #1;
    Cmd_type = 2'd1;
    Addr = 4'h9;
    Data_A = 8'hFF;
    Prescale = 5'd4;
    Parity_EN = 1'b1;
    Cmd_valid = 1'b1;
    @(posedge CLK);
    #1;
    Cmd_valid = 1'b0;
    chk("ignore_busy", Busy, 1);
    wait_done(264, "ignore");
    issue(tbl[1]);
    wait_done(384, "b2b");
    repeat (3) @(posedge CLK);
    issue(tbl[2]);
    repeat (110) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk("midreset_tx", Tx_serial, 1);
    chk("midreset_busy", Busy, 0);
    chk("midreset_done", Frame_done, 0);
    sb.delete();
    repeat (150) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    issue(tbl[6]);
    wait_done(176, "post_reset");
    repeat (4) @(posedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
